// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel colour type and pattern-mode encoding.
package vga_pkg;

  // 640x480 @ 60 Hz default timing, in pixels (horizontal) and lines (vertical)
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Sync asserted level: 0 = active-low
  localparam bit HS_POL_DEF = 1'b0;
  localparam bit VS_POL_DEF = 1'b0;

  localparam int unsigned PIX_DIV_DEF = 1;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } colour_t;

  typedef enum logic {
    MODE_BARS    = 1'b0,
    MODE_CHECKER = 1'b1
  } mode_t;

  // Bar index maps straight onto {r,g,b}: bar 0 black, bar 7 white
  function automatic colour_t bar_colour(input logic [2:0] idx);
    return colour_t'(idx);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap, sync-level decode and active decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF,
  parameter bit          POL    = HS_POL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap,
  output logic       sync,
  output logic       active
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [9:0] LAST       = 10'(TOTAL - 1);
  localparam logic [9:0] ACT_END    = 10'(ACTIVE);
  localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
  localparam logic [9:0] SYNC_END   = 10'(ACTIVE + FP + SYNC);

  // Advance on enable, returning to zero after the last position
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 10'd1;
    end
  end

  // Wrap strobe, sync pin level and visible-region decode from the current count
  always_comb begin
    wrap   = en && (count == LAST);
    sync   = ((count >= SYNC_START) && (count < SYNC_END)) ? POL : ~POL;
    active = (count < ACT_END);
  end

endmodule

// File: rtl/vga_timing_pattern.sv
// VGA timing generator with built-in colour-bar / checkerboard test pattern.
// All outputs are registered from the counter state, one clock behind it.
module vga_timing_pattern
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = HS_POL_DEF,
  parameter bit          VS_POL   = VS_POL_DEF,
  parameter int unsigned PIX_DIV  = PIX_DIV_DEF
) (
  input  logic       _i_clk,
  input  logic       _i_rst,
  input  logic       mode,
  output logic       hsync,
  output logic       vsync,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int unsigned PRE_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PIX_DIV - 1);
  // Remainder pixels of H_ACTIVE/8 fall into the last bar
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

  logic [PRE_W-1:0] pre;
  logic             pix_en;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             h_wrap;
  logic             h_sync;
  logic             h_act;
  logic             v_sync;
  logic             v_act;
  logic             v_wrap_unused;
  logic [2:0]       bar_idx;
  logic [9:0]       bar_cnt;
  mode_t            mode_q;
  colour_t          pat;

  assign pix_en = (pre == PRE_LAST);

  // Pixel prescaler: one pix_en every PIX_DIV clocks
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      pre <= '0;
    end else if (pix_en) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h (
    .clk    (_i_clk),
    .rst    (_i_rst),
    .en     (pix_en),
    .count  (hc),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .active (h_act)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v (
    .clk    (_i_clk),
    .rst    (_i_rst),
    .en     (h_wrap),
    .count  (vc),
    .wrap   (v_wrap_unused),
    .sync   (v_sync),
    .active (v_act)
  );

  // Bar index tracks hc so it can be used directly without a divider
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        bar_idx <= '0;
        bar_cnt <= '0;
      end else if ((bar_cnt == BAR_LAST) && (bar_idx != 3'd7)) begin
        bar_idx <= bar_idx + 3'd1;
        bar_cnt <= '0;
      end else begin
        bar_cnt <= bar_cnt + 10'd1;
      end
    end
  end

  // Pattern select only changes at the frame origin so a frame never tears
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      mode_q <= MODE_BARS;
    end else if (pix_en && (hc == '0) && (vc == '0)) begin
      mode_q <= mode_t'(mode);
    end
  end

  // Pattern colour for the current pixel, black outside the visible region
  always_comb begin
    pat = '0;
    if (h_act && v_act) begin
      if (mode_q == MODE_CHECKER) begin
        pat = colour_t'({3{hc[5] ^ vc[5]}});
      end else begin
        pat = bar_colour(bar_idx);
      end
    end
  end

  // Output registers; frame_start keys on the first clock of pixel (0,0)
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      r           <= 1'b0;
      g           <= 1'b0;
      b           <= 1'b0;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_sync;
      vsync       <= v_sync;
      r           <= pat.r;
      g           <= pat.g;
      b           <= pat.b;
      active      <= h_act && v_act;
      x           <= hc;
      y           <= vc;
      frame_start <= (pre == '0) && (hc == '0) && (vc == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Directed bench: default timing (a), reduced 80x48 timing (b), default timing at PIX_DIV=2 (c).
module tb_vga_timing_pattern;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, mode_a, rst_b, mode_b;

  logic hs_a, vs_a, r_a, g_a, b_a, act_a, fs_a;
  logic [9:0] x_a, y_a;
  logic hs_b, vs_b, r_b, g_b, b_b, act_b, fs_b;
  logic [9:0] x_b, y_b;
  logic hs_c, vs_c, r_c, g_c, b_c, act_c, fs_c;
  logic [9:0] x_c, y_c;

  logic [2:0] rgb_a, rgb_b, rgb_c;
  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};
  assign rgb_c = {r_c, g_c, b_c};

  vga_timing_pattern dut_a (
    ._i_clk(clk), ._i_rst(rst_a), .mode(mode_a),
    .hsync(hs_a), .vsync(vs_a), .r(r_a), .g(g_a), .b(b_a),
    .active(act_a), .x(x_a), .y(y_a), .frame_start(fs_a)
  );

  // 80 x 48 total (64x40 visible) so whole frames are short: 3840 clocks
  vga_timing_pattern #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut_b (
    ._i_clk(clk), ._i_rst(rst_b), .mode(mode_b),
    .hsync(hs_b), .vsync(vs_b), .r(r_b), .g(g_b), .b(b_b),
    .active(act_b), .x(x_b), .y(y_b), .frame_start(fs_b)
  );

  vga_timing_pattern #(.PIX_DIV(2)) dut_c (
    ._i_clk(clk), ._i_rst(rst_a), .mode(mode_a),
    .hsync(hs_c), .vsync(vs_c), .r(r_c), .g(g_c), .b(b_c),
    .active(act_c), .x(x_c), .y(y_c), .frame_start(fs_c)
  );

  int unsigned n_tests;
  int unsigned n_fail;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int unsigned hs_low, hs_first, act_cnt, a_fs, a_bad;
    int unsigned c_bad, c_fs, c_hs_low;
    int unsigned fs_cnt, vs_low, vs_fx, vs_fy, vs_seen, frame, pat_hits;
    int unsigned fs_time [3];
    int unsigned found, gap;

    n_tests = 0; n_fail = 0;
    hs_low = 0; hs_first = 9999; act_cnt = 0; a_fs = 0; a_bad = 0;
    c_bad = 0; c_fs = 0; c_hs_low = 0;
    fs_cnt = 0; vs_low = 0; vs_fx = 9999; vs_fy = 9999; vs_seen = 0; pat_hits = 0;
    fs_time[0] = 0; fs_time[1] = 0; fs_time[2] = 0;
    found = 0; gap = 0;

    rst_a = 1'b1; rst_b = 1'b1; mode_a = 1'b0; mode_b = 1'b0;

    // Reset held for 3 clocks
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_hsync", hs_a, 1);
      check("rst_vsync", vs_a, 1);
      check("rst_rgb", rgb_a, 0);
      check("rst_active", act_a, 0);
      check("rst_x", x_a, 0);
      check("rst_y", y_a, 0);
      check("rst_frame_start", fs_a, 0);
      check("rst_c_outputs", {hs_c, vs_c, rgb_c, act_c}, 6'b110000);
    end
    rst_a = 1'b0;
    // Still showing reset values in the clock right after release
    check("rel_hsync", hs_a, 1);
    check("rel_active", act_a, 0);
    check("rel_frame_start", fs_a, 0);

    // One line on dut_a (800 clocks) and one line on dut_c (1600 clocks)
    for (int unsigned s = 1; s <= 1601; s++) begin
      @(posedge clk); @(negedge clk);
      if (s <= 800) begin
        if (!hs_a) begin
          hs_low++;
          if (hs_first == 9999) hs_first = x_a;
        end
        if (act_a) act_cnt++;
        if (fs_a) a_fs++;
        if ((x_a != s - 1) || (y_a != 0)) a_bad++;
        if (s == 1)   check("bar_x0", rgb_a, 3'b000);
        if (s == 80)  check("bar_x79", rgb_a, 3'b000);
        if (s == 81)  check("bar_x80", rgb_a, 3'b001);
        if (s == 161) check("bar_x160", rgb_a, 3'b010);
        if (s == 401) check("bar_x400", rgb_a, 3'b101);
        if (s == 640) check("bar_x639", rgb_a, 3'b111);
        if (s == 641) check("bar_x640_blank", rgb_a, 3'b000);
        if (s == 641) check("active_x640", act_a, 0);
      end
      if (s == 801) begin
        check("line_wrap_x", x_a, 0);
        check("line_wrap_y", y_a, 1);
      end
      if (s <= 1600) begin
        if ((x_c != (s - 1) / 2) || (y_c != 0)) c_bad++;
        if (fs_c) c_fs++;
        if (!hs_c) c_hs_low++;
      end else begin
        check("div2_line_wrap", {y_c, x_c}, {10'd1, 10'd0});
      end
    end
    check("hsync_low_clocks", hs_low, 96);
    check("hsync_first_x", hs_first, 656);
    check("active_clocks", act_cnt, 640);
    check("frame_start_in_line0", a_fs, 1);
    check("xy_sequence", a_bad, 0);
    check("div2_xy_hold", c_bad, 0);
    check("div2_frame_start", c_fs, 1);
    check("div2_hsync_low", c_hs_low, 192);

    // Three reduced frames on dut_b, mode change requested mid-frame
    rst_b = 1'b0;
    for (int unsigned s = 1; s <= 11520; s++) begin
      @(posedge clk); @(negedge clk);
      frame = (s - 1) / 3840 + 1;
      if (fs_b) begin
        if (fs_cnt < 3) fs_time[fs_cnt] = s;
        fs_cnt++;
      end
      if (frame == 1 && !vs_b) begin
        vs_low++;
        if (vs_seen == 0) begin
          vs_seen = 1; vs_fx = x_b; vs_fy = y_b;
        end
      end
      if (frame == 2 && y_b == 10 && x_b == 0) mode_b = 1'b1;
      if (frame == 3 && y_b == 5 && x_b == 0) mode_b = 1'b0;
      if (frame == 1 && y_b == 0 && x_b == 32) begin
        check("bars_f1_x32", rgb_b, 3'b100); pat_hits++;
      end
      if (frame == 2 && y_b == 20 && x_b == 32) begin
        check("bars_kept_after_mode", rgb_b, 3'b100); pat_hits++;
      end
      if (frame == 3) begin
        if (y_b == 0 && x_b == 32) begin
          check("chk_x32_y0", rgb_b, 3'b111); pat_hits++;
        end
        if (y_b == 20 && x_b == 40) begin
          check("chk_x40_y20", rgb_b, 3'b111); pat_hits++;
        end
        if (y_b == 32 && x_b == 0) begin
          check("chk_x0_y32", rgb_b, 3'b111); pat_hits++;
        end
        if (y_b == 32 && x_b == 32) begin
          check("chk_x32_y32", rgb_b, 3'b000); pat_hits++;
        end
      end
    end
    check("pattern_points", pat_hits, 6);
    check("fs_count", fs_cnt, 3);
    check("fs_first", fs_time[0], 1);
    check("fs_period1", fs_time[1] - fs_time[0], 3840);
    check("fs_period2", fs_time[2] - fs_time[1], 3840);
    check("vsync_low_clocks", vs_low, 160);
    check("vsync_first_y", vs_fy, 42);
    check("vsync_first_x", vs_fx, 0);

    // Mid-frame reset at (30,20)
    found = 0;
    for (int unsigned k = 0; k < 5000 && found == 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (x_b == 30 && y_b == 20) found = 1;
    end
    check("mid_reset_reach", found, 1);
    rst_b = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_b = 1'b0;
    check("mid_rst_xy", {y_b, x_b}, 0);
    check("mid_rst_outputs", {hs_b, vs_b, rgb_b, act_b, fs_b}, 7'b1100000);
    @(posedge clk); @(negedge clk);
    check("post_rst_frame_start", fs_b, 1);
    check("post_rst_active", act_b, 1);
    found = 0;
    for (int unsigned k = 1; k <= 5000 && found == 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (fs_b) begin
        found = 1; gap = k;
      end
    end
    check("post_rst_period", gap, 3840);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
